ucitavanje_uzorka: RTL and testbench
====================================

UCITAVANJE_UZORKA -- requirements
Module: ucitavanje_uzorka

Interface
REQ-001 SHALL have parameter BROJ_ULAZA, default 60, number of 16-bit sample words per frame.
REQ-002 SHALL have parameter SIRINA, default 16, width of one sample word in bits.
REQ-003 SHALL have parameter LATENCIJA, default 3, clock edges from vector load to valid neuron output; legal range 1..15.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port ulaz_podatak  input  SIRINA  serial sample word.
REQ-007 SHALL have port ulaz_valid  input  1  ulaz_podatak is valid this cycle.
REQ-008 SHALL have port ulaz_spreman  output  1  block accepts a word this cycle.
REQ-009 SHALL have port prekid  input  1  discard the partially collected frame.
REQ-010 SHALL have port uzorak  output  BROJ_ULAZA*SIRINA  parallel sample vector for the neuron stage; registered.
REQ-011 SHALL have port uzorak_valid  output  1  one-cycle pulse, new vector present on uzorak.
REQ-012 SHALL have port rezultat_valid  output  1  one-cycle pulse, neuron output for the latest vector is valid.
REQ-013 SHALL have port brojac  output  6  words accepted in the current frame, 0..BROJ_ULAZA-1.

Function
REQ-014 SHALL implement two states: PUNJENJE (collecting words) and CEKANJE (holding the vector while the neuron computes).
REQ-015 SHALL drive ulaz_spreman high only when state is PUNJENJE and rst is low.
REQ-016 SHALL accept a word on a rising edge only when ulaz_valid and ulaz_spreman are both high.
REQ-017 SHALL write the k-th accepted word (k = brojac) into shadow-buffer slot k, then increment brojac.
REQ-018 SHALL, on the edge accepting word BROJ_ULAZA-1, load uzorak so that word k occupies bits [SIRINA*k+SIRINA-1 : SIRINA*k], with the final word taken directly from ulaz_podatak.
REQ-019 SHALL, on that same edge, set uzorak_valid to 1, brojac to 0, and state to CEKANJE.
REQ-020 SHALL clear uzorak_valid on the following edge; it is never high for two consecutive cycles.
REQ-021 SHALL hold uzorak unchanged at all times except at the load edge of REQ-018; partial frames never alter uzorak.
REQ-022 SHALL count edges in CEKANJE with an internal counter cleared at the load edge.
REQ-023 SHALL, on the LATENCIJA-th edge after the load edge, set rezultat_valid to 1 and return state to PUNJENJE.
REQ-024 SHALL clear rezultat_valid on the next edge.
REQ-025 SHALL, when LATENCIJA = 3, place rezultat_valid in the cycle where the neuron's registered izlaz reflects the new uzorak.
REQ-026 SHALL, when prekid is high in PUNJENJE, clear brojac to 0 and discard buffered words, leaving uzorak and the valid outputs unchanged.
REQ-027 SHALL give prekid priority over acceptance: with prekid and ulaz_valid both high, the word is dropped and brojac becomes 0, including on the word that would complete the frame.
REQ-028 SHALL ignore prekid in CEKANJE; the pending rezultat_valid still occurs.
REQ-029 SHALL keep words presented with ulaz_valid high during CEKANJE un-accepted; the upstream source holds them until ulaz_spreman returns high.
REQ-030 SHALL start a new frame in the cycle rezultat_valid is high, accepting a word at the end of that cycle if ulaz_valid is high.

Reset
REQ-031 SHALL, on an edge with rst high, set state to PUNJENJE, uzorak to 0, shadow buffer to 0, brojac to 0, and uzorak_valid, rezultat_valid and the latency counter to 0.
REQ-032 SHALL, on rst mid-frame or mid-CEKANJE, abandon the frame or the pending result, with no uzorak_valid or rezultat_valid pulse afterwards for it.
REQ-033 SHALL give rst priority over prekid and ulaz_valid.

Verification
REQ-034 SHALL cover: after reset, feed 60 words of value k+1 with ulaz_valid held high -> one-cycle uzorak_valid; uzorak[15:0]=1, uzorak[959:944]=60; brojac back at 0.
REQ-035 SHALL cover: same frame, measure from uzorak_valid -> rezultat_valid exactly 3 cycles later; ulaz_spreman low for exactly those 3 cycles and high from the rezultat_valid cycle.
REQ-036 SHALL cover: 30 words, then prekid high for 1 cycle, then 60 words of 0xFFFF -> exactly one uzorak_valid pulse; uzorak all ones; the previous uzorak is unchanged until that pulse.
REQ-037 SHALL cover: prekid and ulaz_valid high together on the 60th word -> no uzorak_valid; brojac = 0.
REQ-038 SHALL cover: rst high for 1 cycle 1 cycle after uzorak_valid -> no rezultat_valid; uzorak = 0; ulaz_spreman = 1 in the cycle after rst falls.
REQ-039 SHALL cover: ulaz_valid toggling every other cycle across two back-to-back frames -> two uzorak_valid pulses, each word captured once, and no words accepted during CEKANJE.

Source files
------------

// File: rtl/ucitavanje_uzorka.sv
// ucitavanje_uzorka
// Collects BROJ_ULAZA serial sample words into a parallel vector for the neuron
// stage. When the frame is complete, the block holds the vector for LATENCIJA
// clock edges while the neuron computes, and then signals that the result is
// valid.
//
// Ports:
//   clk            - single clock; all state changes on its rising edge
//   rst            - synchronous, active-high reset
//   ulaz_podatak   - serial sample word
//   ulaz_valid     - ulaz_podatak is valid this cycle
//   ulaz_spreman   - the block accepts a word this cycle
//   prekid         - discard the partially collected frame (ignored while waiting)
//   uzorak         - registered parallel vector; word k sits at [SIRINA*k +: SIRINA]
//   uzorak_valid   - one-cycle pulse: a new vector is present on uzorak
//   rezultat_valid - one-cycle pulse: the neuron output for the latest vector is valid
//   brojac         - number of words accepted in the current frame
module ucitavanje_uzorka #(
    parameter int unsigned BROJ_ULAZA = 60,
    parameter int unsigned SIRINA     = 16,
    parameter int unsigned LATENCIJA  = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [SIRINA-1:0]              ulaz_podatak,
    input  logic                           ulaz_valid,
    output logic                           ulaz_spreman,
    input  logic                           prekid,
    output logic [BROJ_ULAZA*SIRINA-1:0]   uzorak,
    output logic                           uzorak_valid,
    output logic                           rezultat_valid,
    output logic [5:0]                     brojac
);

    typedef enum logic [0:0] {StPunjenje, StCekanje} stanje_e;

    // The last word goes straight from the input into uzorak, so the shadow
    // buffer only needs to hold the first BROJ_ULAZA-1 words.
    localparam int unsigned BufW       = SIRINA * (BROJ_ULAZA - 1);
    localparam logic [5:0]  ZadnjiIdx  = 6'(BROJ_ULAZA - 1);
    localparam logic [3:0]  ZadnjiTakt = 4'(LATENCIJA - 1);

    stanje_e                         stanje_q, stanje_d;
    logic [5:0]                      brojac_q, brojac_d;
    logic [BufW-1:0]                 buf_q, buf_d;
    logic [BROJ_ULAZA*SIRINA-1:0]    uzorak_q, uzorak_d;
    logic                            uzorak_valid_q, uzorak_valid_d;
    logic                            rezultat_valid_q, rezultat_valid_d;
    logic [3:0]                      takt_q, takt_d;

    assign ulaz_spreman   = (stanje_q == StPunjenje) && !rst;
    assign uzorak         = uzorak_q;
    assign uzorak_valid   = uzorak_valid_q;
    assign rezultat_valid = rezultat_valid_q;
    assign brojac         = brojac_q;

    always_comb begin
        stanje_d         = stanje_q;
        brojac_d         = brojac_q;
        buf_d            = buf_q;
        uzorak_d         = uzorak_q;
        takt_d           = takt_q;
        uzorak_valid_d   = 1'b0;
        rezultat_valid_d = 1'b0;

        unique case (stanje_q)
            StPunjenje: begin
                if (prekid) begin
                    // Dropping the count is enough to discard the frame: stale
                    // slots are overwritten before they are ever loaded again.
                    brojac_d = '0;
                end else if (ulaz_valid) begin
                    if (brojac_q == ZadnjiIdx) begin
                        uzorak_d       = {ulaz_podatak, buf_q};
                        uzorak_valid_d = 1'b1;
                        brojac_d       = '0;
                        takt_d         = '0;
                        stanje_d       = StCekanje;
                    end else begin
                        buf_d[SIRINA*int'(brojac_q) +: SIRINA] = ulaz_podatak;
                        brojac_d = brojac_q + 6'd1;
                    end
                end
            end
            StCekanje: begin
                // takt_q counts edges since the load edge, minus one.
                if (takt_q == ZadnjiTakt) begin
                    rezultat_valid_d = 1'b1;
                    takt_d           = '0;
                    stanje_d         = StPunjenje;
                end else begin
                    takt_d = takt_q + 4'd1;
                end
            end
            default: stanje_d = StPunjenje;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stanje_q         <= StPunjenje;
            brojac_q         <= '0;
            buf_q            <= '0;
            uzorak_q         <= '0;
            uzorak_valid_q   <= 1'b0;
            rezultat_valid_q <= 1'b0;
            takt_q           <= '0;
        end else begin
            stanje_q         <= stanje_d;
            brojac_q         <= brojac_d;
            buf_q            <= buf_d;
            uzorak_q         <= uzorak_d;
            uzorak_valid_q   <= uzorak_valid_d;
            rezultat_valid_q <= rezultat_valid_d;
            takt_q           <= takt_d;
        end
    end

endmodule

// File: tb/tb_ucitavanje_uzorka.sv
// Self-checking bench for ucitavanje_uzorka: directed scenarios plus a random
// phase, every cycle compared against a queue-based frame model.
module tb_ucitavanje_uzorka;

    localparam int N   = 60;
    localparam int W   = 16;
    localparam int LAT = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [W-1:0]     ulaz_podatak = '0;
    logic             ulaz_valid = 1'b0;
    logic             ulaz_spreman;
    logic             prekid = 1'b0;
    logic [N*W-1:0]   uzorak;
    logic             uzorak_valid;
    logic             rezultat_valid;
    logic [5:0]       brojac;

    always #5 clk = ~clk;

    ucitavanje_uzorka #(
        .BROJ_ULAZA (N),
        .SIRINA     (W),
        .LATENCIJA  (LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ulaz_podatak   (ulaz_podatak),
        .ulaz_valid     (ulaz_valid),
        .ulaz_spreman   (ulaz_spreman),
        .prekid         (prekid),
        .uzorak         (uzorak),
        .uzorak_valid   (uzorak_valid),
        .rezultat_valid (rezultat_valid),
        .brojac         (brojac)
    );

    int checks_total = 0;
    int passed       = 0;
    int cyc          = 0;
    int uv_cyc       = -1;
    int rv_cyc       = -1;
    int uv_cnt       = 0;
    int rv_cnt       = 0;

    // Reference model: words of the current frame, the last delivered vector,
    // and how many edges remain until the neuron result is due.
    logic [W-1:0]   m_q[$];
    logic [N*W-1:0] m_uzorak = '0;
    int             m_wait   = 0;
    logic           m_uv     = 1'b0;
    logic           m_rv     = 1'b0;
    logic           m_acc    = 1'b0;

    task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
        checks_total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        m_uv  = 1'b0;
        m_rv  = 1'b0;
        m_acc = 1'b0;
        if (rst) begin
            m_q.delete();
            m_uzorak = '0;
            m_wait   = 0;
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) m_rv = 1'b1;
        end else if (prekid) begin
            m_q.delete();
        end else if (ulaz_valid) begin
            m_acc = 1'b1;
            m_q.push_back(ulaz_podatak);
            if (m_q.size() == N) begin
                for (int k = 0; k < N; k++) m_uzorak[k*W +: W] = m_q[k];
                m_uv   = 1'b1;
                m_wait = LAT;
                m_q.delete();
            end
        end
        chk("uzorak", uzorak, m_uzorak);
        chk("uzorak_valid", (N*W)'(uzorak_valid), (N*W)'(m_uv));
        chk("rezultat_valid", (N*W)'(rezultat_valid), (N*W)'(m_rv));
        chk("brojac", (N*W)'(brojac), (N*W)'(m_q.size()));
        chk("ulaz_spreman", (N*W)'(ulaz_spreman), (N*W)'((m_wait == 0) && !rst));
        if (uzorak_valid) begin uv_cyc = cyc; uv_cnt++; end
        if (rezultat_valid) begin rv_cyc = cyc; rv_cnt++; end
    endtask

    task automatic idle(input int n);
        ulaz_valid = 1'b0;
        prekid     = 1'b0;
        repeat (n) step();
    endtask

    task automatic feed_random(input int n);
        for (int k = 0; k < n; k++) begin
            ulaz_valid   = 1'b1;
            ulaz_podatak = W'($urandom);
            step();
        end
        ulaz_valid = 1'b0;
    endtask

    initial begin
        int low;
        int uv0;
        int rv0;
        int w;

        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("spreman_after_reset", (N*W)'(ulaz_spreman), (N*W)'(1));

        // Full frame of k+1 with valid held high, then latency measurement
        rv_cyc = -1;
        for (int k = 0; k < N; k++) begin
            ulaz_valid   = 1'b1;
            ulaz_podatak = W'(k + 1);
            step();
        end
        ulaz_valid = 1'b0;
        chk("frame1_pulse", (N*W)'(uzorak_valid), (N*W)'(1));
        chk("frame1_word0", (N*W)'(uzorak[15:0]), (N*W)'(1));
        chk("frame1_word59", (N*W)'(uzorak[959:944]), (N*W)'(60));
        chk("frame1_brojac", (N*W)'(brojac), (N*W)'(0));
        low = ulaz_spreman ? 0 : 1;
        repeat (6) begin
            step();
            if (rv_cyc < 0 && !ulaz_spreman) low++;
        end
        chk("latency", (N*W)'(rv_cyc - uv_cyc), (N*W)'(3));
        chk("spreman_low_cycles", (N*W)'(low), (N*W)'(3));

        // 30 words, prekid, then a frame of all ones
        uv0 = uv_cnt;
        feed_random(30);
        prekid = 1'b1;
        step();
        prekid = 1'b0;
        for (int k = 0; k < N; k++) begin
            ulaz_valid   = 1'b1;
            ulaz_podatak = '1;
            step();
        end
        ulaz_valid = 1'b0;
        chk("ones_uzorak", uzorak, {(N*W){1'b1}});
        idle(5);
        chk("ones_pulses", (N*W)'(uv_cnt - uv0), (N*W)'(1));

        // prekid together with the completing word
        uv0 = uv_cnt;
        feed_random(N - 1);
        ulaz_valid = 1'b1;
        prekid     = 1'b1;
        step();
        chk("abort_last_brojac", (N*W)'(brojac), (N*W)'(0));
        idle(4);
        chk("abort_last_pulses", (N*W)'(uv_cnt - uv0), (N*W)'(0));

        // rst one cycle after uzorak_valid kills the pending result
        feed_random(N);
        step();
        rv0 = rv_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("spreman_after_rst_falls", (N*W)'(ulaz_spreman), (N*W)'(1));
        idle(6);
        chk("rst_no_result", (N*W)'(rv_cnt - rv0), (N*W)'(0));
        chk("rst_uzorak_zero", uzorak, '0);

        // Toggling valid across two back-to-back frames; words held while waiting
        uv0 = uv_cnt;
        w = 0;
        for (int i = 0; i < 600 && w < 2 * N; i++) begin
            ulaz_valid   = (i % 2 == 0);
            ulaz_podatak = W'(w + 100);
            step();
            if (m_acc) w++;
        end
        idle(5);
        chk("toggle_words", (N*W)'(w), (N*W)'(2 * N));
        chk("toggle_pulses", (N*W)'(uv_cnt - uv0), (N*W)'(2));

        // Random phase
        for (int i = 0; i < 2000; i++) begin
            ulaz_valid   = ($urandom_range(0, 3) != 0);
            ulaz_podatak = W'($urandom);
            prekid       = ($urandom_range(0, 199) == 0);
            rst          = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        idle(6);

        $display("%0d/%0d checks passed", passed, checks_total);
        $finish;
    end

endmodule
